// File: rtl/aes_pkg.sv
// Shared constants, GF(2^8) helpers and FSM state type for the AES inverse cipher.
package aes_pkg;

  localparam int unsigned BYTE   = 8;
  localparam int unsigned LENGTH = 128;
  localparam int unsigned NR     = 10;
  localparam logic [7:0]  POLY   = 8'h1b;  // x^8 + x^4 + x^3 + x + 1, top bit implied

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  // Multiply by x modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
  endfunction

  // General GF(2^8) product; the round uses it with 09/0b/0d/0e.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Row r rotates right by r; byte b[r+4c] sits at bits [127-8(r+4c) -: 8].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] o0, o1, o2, o3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    o0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    o1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    o2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    o3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    return {o0, o1, o2, o3};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: inverse affine transform, then GF(2^8) inverse.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [BYTE-1:0] data_i,
  output logic [BYTE-1:0] data_o
);

  logic [7:0] aff;
  logic [7:0] p2, p4, p8, p16, p32, p64, p128;
  logic [7:0] t6, t14, t30, t62, t126;

  // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  assign aff = {data_i[6:0], data_i[7]} ^ {data_i[4:0], data_i[7:5]} ^
               {data_i[1:0], data_i[7:2]} ^ 8'h05;

  // a^-1 = a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as required.
  assign p2   = gf_mul(aff, aff);
  assign p4   = gf_mul(p2, p2);
  assign p8   = gf_mul(p4, p4);
  assign p16  = gf_mul(p8, p8);
  assign p32  = gf_mul(p16, p16);
  assign p64  = gf_mul(p32, p32);
  assign p128 = gf_mul(p64, p64);

  assign t6   = gf_mul(p2, p4);
  assign t14  = gf_mul(t6, p8);
  assign t30  = gf_mul(t14, p16);
  assign t62  = gf_mul(t30, p32);
  assign t126 = gf_mul(t62, p64);

  assign data_o = gf_mul(t126, p128);

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 inverse cipher, one decryption round per clock.
module aes_inv_cipher_core
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] in_data,
  output logic [3:0]        rk_idx,
  input  logic [LENGTH-1:0] rk,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] out_data
);

  localparam logic [3:0] NrIdx = 4'(NR);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [LENGTH-1:0] data_q, data_d;
  logic [LENGTH-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [LENGTH-1:0] sr, sb, ark, mixed;

  assign sr = inv_shift_rows(data_q);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .data_i(sr[LENGTH-1-BYTE*i -: BYTE]),
      .data_o(sb[LENGTH-1-BYTE*i -: BYTE])
    );
  end

  assign ark   = sb ^ rk;
  assign mixed = inv_mix_columns(ark);

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Next-state logic and round-key index selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rk_idx      = NrIdx;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = in_data ^ rk;
          cnt_d   = NrIdx - 4'd1;
          state_d = StRound;
        end
      end
      StRound: begin
        rk_idx = cnt_q;
        if (cnt_q != 4'd0) begin
          data_d = mixed;
          cnt_d  = cnt_q - 4'd1;
        end else begin
          // Final round skips InvMixColumns.
          out_data_d  = ark;
          out_valid_d = 1'b1;
          cnt_d       = NrIdx;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= NrIdx;
      data_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Scoreboard bench for aes_inv_cipher_core using FIPS-197 vectors.
module tb_aes_inv_cipher_core;
  import aes_pkg::*;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  logic [7:0]   sb_in, sb_out;

  int n_pass  = 0;
  int n_total = 0;
  int key_sel = 0;

  logic [127:0] exp_q[$];

  // Key schedule for key 000102...0f (FIPS-197 C.1).
  localparam logic [127:0] KS_A [0:10] = '{
    128'h000102030405060708090a0b0c0d0e0f,
    128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe,
    128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd,
    128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b,
    128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2,
    128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5
  };

  // Key schedule for key 2b7e1516...4f3c (FIPS-197 App. A.1 / B).
  localparam logic [127:0] KS_B [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  localparam logic [127:0] CT_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;

  aes_inv_cipher_core dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .rk_idx   (rk_idx),
    .rk       (rk),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  aes_inv_sbox u_sbox (
    .data_i(sb_in),
    .data_o(sb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational key store.
  always_comb begin
    rk = '0;
    if (int'(rk_idx) <= 10) rk = (key_sel == 0) ? KS_A[int'(rk_idx)] : KS_B[int'(rk_idx)];
  end

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  // Monitor: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out: got %h, expected no output", out_data);
      end else begin
        check("plaintext", out_data, exp_q.pop_front());
      end
    end
  end

  // Waits for IDLE (bounded), presents a block and returns just after the accept edge.
  task automatic accept(input logic [127:0] ct, input logic [127:0] pt, input int ks,
                        input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 128'(in_ready), 128'd1);
    check("idle_rk_idx", 128'(rk_idx), 128'd10);
    key_sel  = ks;
    in_valid = 1'b1;
    in_data  = ct;
    if (push) exp_q.push_back(pt);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Checks rk_idx 9..0 during rounds and out_valid rising exactly 10 edges after accept.
  task automatic wait_latency();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("round_rk_idx", 128'(rk_idx), 128'(9 - k));
      check("no_early_valid", 128'(out_valid), 128'd0);
    end
    @(negedge clk);
    check("valid_at_10", 128'(out_valid), 128'd1);
    check("done_rk_idx", 128'(rk_idx), 128'd10);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    sb_in     = 8'h00;

    // Unit checks on the S-box and column mix.
    sb_in = 8'h63; #1 check("sbox_63", 128'(sb_out), 128'h00);
    sb_in = 8'h00; #1 check("sbox_00", 128'(sb_out), 128'h52);
    sb_in = 8'h16; #1 check("sbox_16", 128'(sb_out), 128'hff);
    check("inv_mix_column", 128'(inv_mix_column(32'h8e4da1bc)), 128'hdb135345);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_rk_idx", 128'(rk_idx), 128'd10);

    // C.1 and App. B with free-flowing output.
    accept(CT_A, PT_A, 0, 1'b1);
    wait_latency();
    accept(CT_B, PT_B, 1, 1'b1);
    wait_latency();

    // Back-pressure: hold output for 5 cycles, pulse in_valid meanwhile.
    @(posedge clk);
    #1 out_ready = 1'b0;
    accept(CT_A, PT_A, 0, 1'b1);
    wait_latency();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i % 2 == 0);
      in_data  = 128'hdeadbeef_cafef00d_01234567_89abcdef;
      @(negedge clk);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_out_data", out_data, PT_A);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_hs_in_ready", 128'(in_ready), 128'd1);
    check("post_hs_out_valid", 128'(out_valid), 128'd0);
    check("post_hs_out_data", out_data, PT_A);
    accept(CT_B, PT_B, 1, 1'b1);
    wait_latency();

    // Reset in the middle of the rounds: no output for the aborted block.
    accept(CT_A, PT_A, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 128'(in_ready), 128'd1);
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_out_data", out_data, 128'd0);
    accept(CT_A, PT_A, 0, 1'b1);
    wait_latency();

    // Back-to-back with in_valid held high across two blocks.
    accept(CT_B, PT_B, 1, 1'b1);
    in_valid = 1'b1;
    in_data  = CT_A;
    exp_q.push_back(PT_A);
    wait_latency();
    @(negedge clk);
    check("b2b_idle_gap", 128'(in_ready), 128'd1);
    key_sel = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    wait_latency();

    // Drain the scoreboard.
    for (int n = 0; n < 50 && exp_q.size() > 0; n++) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
